// File: rtl/cpu_cache_pkg.sv
// Shared definitions for the snooping MSI cache: bus message layout,
// line coherence encodings and controller state encodings.
package cpu_cache_pkg;

    localparam int LINES  = 4;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 4;
    localparam int MSG_W  = 13;

    localparam int MSG_WB       = 12;
    localparam int MSG_MISS     = 11;
    localparam int MSG_SNOOP    = 10;
    localparam int MSG_INV      = 9;
    localparam int MSG_FILL     = 8;
    localparam int MSG_PEER     = 7;
    localparam int MSG_ADDR_LSB = 4;

    typedef enum logic [1:0] {
        MSI_I = 2'b00,
        MSI_S = 2'b01,
        MSI_M = 2'b10
    } msi_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WB     = 3'd2,
        ST_MISS   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Address and data fields of a message; flag bits are OR'd in by the caller.
    function automatic logic [MSG_W-1:0] pack_msg(input logic [ADDR_W-1:0] addr,
                                                   input logic [DATA_W-1:0] data);
        logic [MSG_W-1:0] m;
        m = '0;
        m[MSG_ADDR_LSB +: ADDR_W] = addr;
        m[DATA_W-1:0] = data;
        return m;
    endfunction

endpackage

// File: rtl/cpu_cache_memory.sv
// Backing store companion: 8 x 4-bit words, synchronous write, registered read.
module memory
    import cpu_cache_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < (1<<ADDR_W); i++) begin
                mem_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (write) begin
                mem_q[address] <= data_in;
            end
            rd_q <= mem_q[address];
        end
    end

    assign data_out = rd_q;

endmodule

// File: rtl/cpu_cache.sv
// Four-line direct-mapped MSI cache controller with snoop handling on a
// single 13-bit message bus.
module cpu_cache
    import cpu_cache_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              execute_instruction,
    input  logic              instruction,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    input  logic [MSG_W-1:0]  bus_in,
    output logic [MSG_W-1:0]  bus_out
);

    state_e            state_q, state_d;
    logic              instr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [MSG_W-1:0]  bus_q, bus_d;

    msi_e              st_q   [0:LINES-1];
    msi_e              st_d   [0:LINES-1];
    msi_e              st_snp [0:LINES-1];
    logic              tag_q  [0:LINES-1];
    logic              tag_d  [0:LINES-1];
    logic [DATA_W-1:0] dat_q  [0:LINES-1];
    logic [DATA_W-1:0] dat_d  [0:LINES-1];

    logic       snp_vld, snp_hit, snp_sup;
    logic [1:0] snp_idx;
    logic [1:0] idx;
    logic       hit, victim_m, fill_ok, inv_emit;
    logic       bus_unused;

    assign bus_unused = ^{bus_in[MSG_WB], bus_in[MSG_MISS], bus_in[MSG_PEER]};

    assign snp_vld = bus_in[MSG_SNOOP] & ~bus_in[MSG_FILL];
    assign snp_idx = bus_in[MSG_ADDR_LSB +: 2];
    assign snp_hit = snp_vld && (st_q[snp_idx] != MSI_I)
                     && (tag_q[snp_idx] == bus_in[MSG_ADDR_LSB+2]);
    assign snp_sup = snp_hit && (st_q[snp_idx] == MSI_M);

    // The snoop is applied first so a same-cycle lookup sees the downgraded line.
    always_comb begin
        st_snp = st_q;
        if (snp_hit) begin
            st_snp[snp_idx] = bus_in[MSG_INV] ? MSI_I : MSI_S;
        end
    end

    assign idx      = addr_q[1:0];
    assign hit      = (st_snp[idx] != MSI_I) && (tag_q[idx] == addr_q[2]);
    assign victim_m = (st_snp[idx] == MSI_M);
    assign fill_ok  = bus_in[MSG_FILL] && (bus_in[MSG_ADDR_LSB +: ADDR_W] == addr_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (execute_instruction) state_d = ST_LOOKUP;
            ST_LOOKUP: begin
                if (hit)           state_d = ST_DONE;
                else if (victim_m) state_d = ST_WB;
                else               state_d = ST_MISS;
            end
            ST_WB:     if (bus_in[MSG_FILL]) state_d = ST_MISS;
            ST_MISS:   if (fill_ok) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done = (state_q == ST_DONE);
    end

    always_comb begin
        st_d     = st_snp;
        tag_d    = tag_q;
        dat_d    = dat_q;
        dout_d   = dout_q;
        inv_emit = 1'b0;
        case (state_q)
            ST_LOOKUP: begin
                if (hit) begin
                    if (instr_q) begin
                        inv_emit   = (st_snp[idx] == MSI_S);
                        st_d[idx]  = MSI_M;
                        dat_d[idx] = wdata_q;
                        dout_d     = wdata_q;
                    end else begin
                        dout_d = dat_q[idx];
                    end
                end
            end
            ST_WB: begin
                if (bus_in[MSG_FILL]) st_d[idx] = MSI_I;
            end
            ST_MISS: begin
                if (fill_ok) begin
                    tag_d[idx] = addr_q[2];
                    if (instr_q) begin
                        st_d[idx]  = MSI_M;
                        dat_d[idx] = wdata_q;
                        dout_d     = wdata_q;
                    end else begin
                        st_d[idx]  = MSI_S;
                        dat_d[idx] = bus_in[DATA_W-1:0];
                        dout_d     = bus_in[DATA_W-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    // Outgoing message follows the state being entered; a peer data supply wins.
    always_comb begin
        bus_d = '0;
        if (snp_sup) begin
            bus_d = pack_msg(bus_in[MSG_ADDR_LSB +: ADDR_W], dat_q[snp_idx]);
            bus_d[MSG_PEER] = 1'b1;
            bus_d[MSG_WB]   = 1'b1;
        end else if (state_d == ST_WB) begin
            bus_d = pack_msg({tag_q[idx], idx}, dat_q[idx]);
            bus_d[MSG_WB] = 1'b1;
        end else if (state_d == ST_MISS) begin
            bus_d = pack_msg(addr_q, '0);
            bus_d[MSG_MISS]  = 1'b1;
            bus_d[MSG_SNOOP] = 1'b1;
            bus_d[MSG_INV]   = instr_q;
        end else if (inv_emit) begin
            bus_d = pack_msg(addr_q, wdata_q);
            bus_d[MSG_SNOOP] = 1'b1;
            bus_d[MSG_INV]   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                st_q[i]  <= MSI_I;
                tag_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
            instr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            bus_q   <= '0;
        end else begin
            st_q   <= st_d;
            tag_q  <= tag_d;
            dat_q  <= dat_d;
            dout_q <= dout_d;
            bus_q  <= bus_d;
            if (state_q == ST_IDLE && execute_instruction) begin
                instr_q <= instruction;
                addr_q  <= address;
                wdata_q <= data_in;
            end
        end
    end

    assign data_out = dout_q;
    assign bus_out  = bus_q;

endmodule

// File: tb/tb_cpu_cache.sv
// Directed and randomized bench for cpu_cache against a line-level MSI
// reference model, plus a short check of the companion memory.
module tb_cpu_cache;

    logic        clock = 1'b0;
    logic        reset;
    logic        execute_instruction;
    logic        instruction;
    logic [2:0]  address;
    logic [3:0]  data_in;
    logic [3:0]  data_out;
    logic        done;
    logic [12:0] bus_in;
    logic [12:0] bus_out;

    logic        m_write;
    logic [2:0]  m_addr;
    logic [3:0]  m_din;
    logic [3:0]  m_dout;

    localparam logic [12:0] F_WB    = 13'h1000;
    localparam logic [12:0] F_MISS  = 13'h0800;
    localparam logic [12:0] F_SNOOP = 13'h0400;
    localparam logic [12:0] F_INV   = 13'h0200;
    localparam logic [12:0] F_FILL  = 13'h0100;
    localparam logic [12:0] F_PEER  = 13'h0080;

    always #5 clock = ~clock;

    cpu_cache dut (
        .clock(clock), .reset(reset),
        .execute_instruction(execute_instruction), .instruction(instruction),
        .address(address), .data_in(data_in), .data_out(data_out), .done(done),
        .bus_in(bus_in), .bus_out(bus_out)
    );

    memory mem_u (
        .clock(clock), .reset(reset), .write(m_write), .address(m_addr),
        .data_in(m_din), .data_out(m_dout)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: line state 0=I 1=S 2=M, tag, data; backing memory contents.
    int mst [4];
    int mtag[4];
    int mdat[4];
    int mmem[8];

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] msg(input logic [12:0] flags, input int a, input int d);
        logic [12:0] m;
        m = flags;
        m[6:4] = a[2:0];
        m[3:0] = d[3:0];
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mst[i] = 0; mtag[i] = 0; mdat[i] = 0;
        end
    endtask

    // One CPU request with the bench acting as memory/bus responder.
    task automatic op(input bit w, input int a, input int wd, input bit snp_lookup);
        int idx, tg, exp_lat, lat, done_cnt;
        bit hit;
        logic [12:0] exp_wb, exp_miss, exp_other, wb_seen, miss_seen, other_seen;
        logic [3:0] exp_dout, dout_seen;
        idx = a & 3; tg = (a >> 2) & 1;
        exp_wb = '0; exp_miss = '0; exp_other = '0;
        wb_seen = '0; miss_seen = '0; other_seen = '0;
        lat = -1; done_cnt = 0; dout_seen = '0;
        if (snp_lookup && mst[idx] != 0 && mtag[idx] == tg) mst[idx] = 0;
        hit = (mst[idx] != 0) && (mtag[idx] == tg);
        if (hit) begin
            exp_lat = 2;
            if (w) begin
                if (mst[idx] == 1) exp_other = msg(F_SNOOP | F_INV, a, wd);
                mst[idx] = 2; mdat[idx] = wd & 15; exp_dout = wd[3:0];
            end else begin
                exp_dout = mdat[idx][3:0];
            end
        end else begin
            exp_lat = 3;
            if (mst[idx] == 2) begin
                exp_lat = 4;
                exp_wb = msg(F_WB, (mtag[idx] << 2) | idx, mdat[idx]);
                mmem[(mtag[idx] << 2) | idx] = mdat[idx];
            end
            exp_miss = msg(F_MISS | F_SNOOP | (w ? F_INV : 13'h0), a, 0);
            mtag[idx] = tg;
            mst[idx]  = w ? 2 : 1;
            mdat[idx] = w ? (wd & 15) : mmem[a];
            exp_dout  = mdat[idx][3:0];
        end

        @(negedge clock);
        execute_instruction = 1'b1; instruction = w; address = a[2:0]; data_in = wd[3:0];
        @(negedge clock);
        execute_instruction = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (bus_out[12] && !bus_out[7]) begin
                wb_seen = bus_out; bus_in = F_FILL;
            end else if (bus_out[11]) begin
                miss_seen = bus_out; bus_in = msg(F_FILL, a, mmem[a]);
            end else begin
                if (bus_out != 13'h0) other_seen = bus_out;
                bus_in = '0;
            end
            if (cyc == 1 && snp_lookup) bus_in = msg(F_SNOOP | F_INV, a, 0);
            if (done === 1'b1) begin
                done_cnt++;
                if (lat < 0) begin lat = cyc; dout_seen = data_out; end
            end
            if (lat >= 0 && cyc >= lat + 1) break;
            @(negedge clock);
        end
        bus_in = '0;
        check($sformatf("latency a=%0d w=%0d", a, w), 13'(lat), 13'(exp_lat));
        check($sformatf("done pulses a=%0d", a), 13'(done_cnt), 13'd1);
        check($sformatf("data_out a=%0d w=%0d", a, w), {9'h0, dout_seen}, {9'h0, exp_dout});
        check($sformatf("writeback msg a=%0d", a), wb_seen, exp_wb);
        check($sformatf("miss msg a=%0d", a), miss_seen, exp_miss);
        check($sformatf("other bus msg a=%0d", a), other_seen, exp_other);
    endtask

    // Peer snoop while the cache is idle; checks the response one cycle later.
    task automatic snoop(input bit inv, input int a);
        int idx, tg;
        logic [12:0] exp;
        idx = a & 3; tg = (a >> 2) & 1; exp = '0;
        if (mst[idx] != 0 && mtag[idx] == tg) begin
            if (mst[idx] == 2) exp = msg(F_PEER | F_WB, a, mdat[idx]);
            mst[idx] = inv ? 0 : 1;
        end
        @(negedge clock);
        bus_in = msg(F_SNOOP | F_MISS | (inv ? F_INV : 13'h0), a, 0);
        @(negedge clock);
        bus_in = '0;
        check($sformatf("snoop resp a=%0d inv=%0d", a, inv), bus_out, exp);
        @(negedge clock);
        check($sformatf("snoop quiet a=%0d", a), bus_out, 13'h0);
    endtask

    initial begin
        bit quiet;
        reset = 1'b1; execute_instruction = 1'b0; instruction = 1'b0;
        address = '0; data_in = '0; bus_in = '0;
        m_write = 1'b0; m_addr = '0; m_din = '0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset data_out", {9'h0, data_out}, 13'h0);
        check("reset done", {12'h0, done}, 13'h0);
        check("reset bus_out", bus_out, 13'h0);
        reset = 1'b0;

        @(negedge clock);
        check("memory reset read", {9'h0, m_dout}, 13'h0);
        m_write = 1'b1; m_addr = 3'd3; m_din = 4'h9;
        @(negedge clock);
        m_addr = 3'd6; m_din = 4'h4;
        @(negedge clock);
        m_write = 1'b0; m_addr = 3'd3;
        @(negedge clock);
        check("memory read 3", {9'h0, m_dout}, 13'h9);
        m_addr = 3'd6;
        @(negedge clock);
        check("memory read 6", {9'h0, m_dout}, 13'h4);

        for (int i = 0; i < 8; i++) mmem[i] = $urandom_range(0, 15);
        mmem[5] = 7;

        op(0, 5, 0, 0);
        op(0, 5, 0, 0);
        op(1, 5, 4'hA, 0);
        op(0, 5, 0, 0);
        op(0, 1, 0, 0);
        op(1, 5, 4'hA, 0);
        snoop(0, 5);
        op(0, 5, 0, 0);
        snoop(1, 5);
        op(0, 5, 0, 0);
        op(0, 2, 0, 0);
        op(0, 2, 0, 1);

        // Reset while waiting on a fill: no completion, bus goes quiet.
        @(negedge clock);
        execute_instruction = 1'b1; instruction = 1'b0; address = 3'd3;
        @(negedge clock);
        execute_instruction = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        quiet = 1'b1;
        repeat (4) begin
            if (done !== 1'b0 || bus_out !== 13'h0) quiet = 1'b0;
            @(negedge clock);
        end
        check("abort quiet", {12'h0, quiet}, 13'h1);
        check("abort data_out", {9'h0, data_out}, 13'h0);

        reset = 1'b1; execute_instruction = 1'b1; address = 3'd5;
        @(negedge clock);
        reset = 1'b0; execute_instruction = 1'b0;
        quiet = 1'b1;
        repeat (4) begin
            if (done !== 1'b0 || bus_out !== 13'h0) quiet = 1'b0;
            @(negedge clock);
        end
        check("exec under reset ignored", {12'h0, quiet}, 13'h1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                snoop(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            else
                op(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 15)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
